// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter run-control sequencer with far-target LUT and watchdog
module pc_sequencer #(
    parameter int PC_BITS    = 12,
    parameter int LUT_DEPTH  = 4,
    parameter int LUT0_RESET = 470,
    parameter int LUT1_RESET = 435,
    parameter int CNT_BITS   = 16,
    parameter int MAX_CYCLES = 4096,
    localparam int IDX_BITS  = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [7:0]          branch_code,
    input  logic                cfg_we,
    input  logic [IDX_BITS-1:0] cfg_idx,
    input  logic [PC_BITS-1:0]  cfg_data,
    output logic                pc_clear,
    output logic                pc_inc,
    output logic                pc_load,
    output logic [PC_BITS-1:0]  pc_target,
    output logic                busy,
    output logic                done,
    output logic                timeout,
    output logic [CNT_BITS-1:0] cycle_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Codes at or above this value index the far-target LUT.
    localparam logic [8:0] LUT_BASE = 9'(256 - LUT_DEPTH);

    // A limit of zero turns the watchdog off entirely.
    localparam bit WD_EN = (MAX_CYCLES != 0);
    localparam logic [CNT_BITS-1:0] WD_LAST = CNT_BITS'(WD_EN ? MAX_CYCLES - 1 : 0);

    state_t               state_q, state_d;
    logic [CNT_BITS-1:0]  cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [PC_BITS-1:0]   lut_q [LUT_DEPTH];
    logic [PC_BITS-1:0]   lut_d [LUT_DEPTH];

    logic                 clear_c, inc_c, load_c;
    logic                 wd_hit;
    logic                 lut_hit;
    logic [IDX_BITS-1:0]  lut_idx;
    logic [CNT_BITS-1:0]  cnt_sat_inc;

    function automatic logic [PC_BITS-1:0] lut_reset_val(input int i);
        if (i == 0) return PC_BITS'(LUT0_RESET);
        if (i == 1) return PC_BITS'(LUT1_RESET);
        return '0;
    endfunction

    // Target resolution: code 255 maps to entry 0, 254 to entry 1, and so on;
    // 255 - code is the bitwise inverse of the low code bits.
    always_comb begin
        lut_hit   = ({1'b0, branch_code} >= LUT_BASE);
        lut_idx   = ~branch_code[IDX_BITS-1:0];
        pc_target = PC_BITS'(branch_code);
        if (lut_hit) begin
            pc_target = lut_q[lut_idx];
        end
    end

    // Saturating increment and watchdog compare for the run-cycle counter.
    always_comb begin
        cnt_sat_inc = (cnt_q == {CNT_BITS{1'b1}}) ? cnt_q : cnt_q + CNT_BITS'(1);
        wd_hit      = WD_EN && (cnt_q == WD_LAST);
    end

    // Run-control next state and Mealy PC commands; first matching rule wins in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        clear_c   = 1'b0;
        inc_c     = 1'b0;
        load_c    = 1'b0;
        case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    clear_c   = 1'b1;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (start) begin
                    clear_c = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_sat_inc;
                    if (halt_req) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b0;
                    end else if (wd_hit) begin
                        state_d   = ST_HALT;
                        timeout_d = 1'b1;
                    end else if (stall) begin
                        // hold PC; a taken branch under stall is dropped
                    end else if (branch_taken) begin
                        load_c = 1'b1;
                    end else begin
                        inc_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // LUT write port; the read above still sees the pre-write contents this cycle.
    always_comb begin
        lut_d = lut_q;
        if (cfg_we && (int'(cfg_idx) < LUT_DEPTH)) begin
            lut_d[cfg_idx] = cfg_data;
        end
    end

    // State, counter, timeout flag and LUT registers; reset also restores LUT defaults.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_q[i] <= lut_reset_val(i);
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            lut_q     <= lut_d;
        end
    end

    // PC commands are suppressed while reset is held so the PC never moves under reset.
    always_comb begin
        pc_clear    = clear_c & ~reset;
        pc_inc      = inc_c & ~reset;
        pc_load     = load_c & ~reset;
        busy        = (state_q == ST_RUN);
        done        = (state_q == ST_HALT);
        timeout     = timeout_q;
        cycle_count = cnt_q;
    end

endmodule
